// File: rtl/r2mdc_pkg.sv
// r2mdc_pkg: shared types and geometry helpers for the R2MDC stage controller.
// Holds the Q7.8 operand format, the controller state encoding and the
// per-stage delay / span / address-width derivation used by every stage.
package r2mdc_pkg;

    // Q7.8 operand format carried by the butterfly datapath (sign + 7 + 8)
    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 8;
    localparam int DATA_W    = 1 + INT_BITS + FRAC_BITS;

    // Controller states; the encodings are fixed so that debug taps agree
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Delay-line depth of a stage: D = N >> (STAGE + 2)
    function automatic int r2mdc_delay(input int n, input int stage);
        return n >> (stage + 2);
    endfunction

    // Butterfly span of a stage: S = 2D
    function automatic int r2mdc_span(input int n, input int stage);
        return 2 * r2mdc_delay(n, stage);
    endfunction

    // Width of the twiddle address and of the pair / butterfly counters
    function automatic int r2mdc_addr_w(input int n);
        return $clog2(n) - 1;
    endfunction

endpackage

// File: rtl/r2mdc_stage_ctrl_if.sv
// r2mdc_stage_ctrl_if: handshake and control bundle between one R2MDC stage
// controller (master side) and the stage wrapper that owns the delay lines
// and the butterfly (slave side).
// Optional macro R2MDC_CTRL_STATS_EN adds the frame_cnt / proto_err signals.
interface r2mdc_stage_ctrl_if #(
    parameter int N = 16
);
    localparam int AW = $clog2(N) - 1;

    logic          in_valid;
    logic          in_ready;
    logic          flush_req;
    logic          sw_in;
    logic          sh_en;
    logic          bf_en;
    logic [AW-1:0] tw_addr;
    logic          sw_out;
    logic          flush_busy;
    logic          frame_last;
`ifdef R2MDC_CTRL_STATS_EN
    logic [7:0]    frame_cnt;
    logic          proto_err;
`endif

`ifdef R2MDC_CTRL_STATS_EN
    modport master (
        input  in_valid, flush_req,
        output in_ready, sw_in, sh_en, bf_en, tw_addr, sw_out,
               flush_busy, frame_last, frame_cnt, proto_err
    );
    modport slave (
        output in_valid, flush_req,
        input  in_ready, sw_in, sh_en, bf_en, tw_addr, sw_out,
               flush_busy, frame_last, frame_cnt, proto_err
    );
`else
    modport master (
        input  in_valid, flush_req,
        output in_ready, sw_in, sh_en, bf_en, tw_addr, sw_out,
               flush_busy, frame_last
    );
    modport slave (
        output in_valid, flush_req,
        input  in_ready, sw_in, sh_en, bf_en, tw_addr, sw_out,
               flush_busy, frame_last
    );
`endif

endinterface

// File: rtl/r2mdc_tw_agen.sv
// r2mdc_tw_agen: twiddle address generator shared by every R2MDC stage.
// Maps the butterfly count to the LUT address (j = bcnt mod S, addr = j << STAGE)
// and flags the last butterfly of a frame.
module r2mdc_tw_agen
    import r2mdc_pkg::*;
#(
    parameter int N     = 16,
    parameter int STAGE = 1
) (
    input  logic [r2mdc_addr_w(N)-1:0] bcnt,
    input  logic                       bf_en,
    output logic [r2mdc_addr_w(N)-1:0] tw_addr,
    output logic                       frame_last
);
    localparam int AW = r2mdc_addr_w(N);
    localparam int S  = r2mdc_span(N, STAGE);
    localparam logic [AW-1:0] J_MASK  = AW'(S - 1);
    localparam logic [AW-1:0] BF_LAST = AW'(N / 2 - 1);

    // S is a power of two, so the modulo is a mask; the shift never overflows
    always_comb begin
        tw_addr    = (bcnt & J_MASK) << STAGE;
        frame_last = bf_en && (bcnt == BF_LAST);
    end

endmodule

// File: rtl/r2mdc_stage_ctrl.sv
// r2mdc_stage_ctrl: sequencing controller for one R2MDC pipeline stage.
// Tracks accepted lane pairs and butterflies, drives the commutator selects,
// delay-line shift enable, butterfly valid and twiddle address, and runs a
// D-cycle flush that drains the delay lines at end of stream.
// Optional macro R2MDC_CTRL_STATS_EN adds frame_cnt and sticky proto_err.
module r2mdc_stage_ctrl
    import r2mdc_pkg::*;
#(
    parameter int N     = 16,
    parameter int STAGE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    r2mdc_stage_ctrl_if.master ctl
);
    localparam int LOGN = $clog2(N);
    localparam int CW   = LOGN - 1;
    localparam int D    = r2mdc_delay(N, STAGE);
    localparam int SWB  = $clog2(D);
    localparam logic [CW-1:0] D_LAST    = CW'(D - 1);
    localparam logic [CW-1:0] PAIR_LAST = CW'(N / 2 - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          sw_out_q, sw_out_d;

    logic          in_ready;
    logic          accept;
    logic          pcnt_wrap;
    logic          sw_in;
    logic          sh_en;
    logic          bf_en;
    logic [CW-1:0] tw_addr;
    logic          frame_last;

    // Next-state decode; bf_en/sh_en follow the accept in the same cycle
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        bcnt_d       = bcnt_q;
        flush_pend_d = flush_pend_q;
        in_ready     = (state_q != ST_FLUSH);
        accept       = ctl.in_valid && in_ready;
        pcnt_wrap    = accept && (pcnt_q == PAIR_LAST);
        sw_in        = pcnt_q[SWB];
        sw_out_d     = sw_in;
        sh_en        = 1'b0;
        bf_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_en   = 1'b1;
                    pcnt_d  = ONE;
                    bcnt_d  = '0;
                    state_d = (D == 1) ? ST_RUN : ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    sh_en  = 1'b1;
                    pcnt_d = pcnt_q + ONE;
                    if (pcnt_q == D_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (ctl.flush_req) begin
                    flush_pend_d = 1'b1;
                end
                if (accept) begin
                    sh_en  = 1'b1;
                    bf_en  = 1'b1;
                    pcnt_d = pcnt_q + ONE;
                    bcnt_d = bcnt_q + ONE;
                    if (pcnt_wrap && (flush_pend_q || ctl.flush_req)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                sh_en  = 1'b1;
                bf_en  = 1'b1;
                pcnt_d = pcnt_q + ONE;
                bcnt_d = bcnt_q + ONE;
                if (pcnt_q == D_LAST) begin
                    state_d      = ST_IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            bcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            sw_out_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            bcnt_q       <= bcnt_d;
            flush_pend_q <= flush_pend_d;
            sw_out_q     <= sw_out_d;
        end
    end

    r2mdc_tw_agen #(
        .N     (N),
        .STAGE (STAGE)
    ) u_tw_agen (
        .bcnt       (bcnt_q),
        .bf_en      (bf_en),
        .tw_addr    (tw_addr),
        .frame_last (frame_last)
    );

    assign ctl.in_ready   = in_ready;
    assign ctl.sw_in      = sw_in;
    assign ctl.sh_en      = sh_en;
    assign ctl.bf_en      = bf_en;
    assign ctl.tw_addr    = tw_addr;
    assign ctl.sw_out     = sw_out_q;
    assign ctl.flush_busy = (state_q == ST_FLUSH);
    assign ctl.frame_last = frame_last;

`ifdef R2MDC_CTRL_STATS_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       proto_err_q, proto_err_d;

    // Frame counter and sticky error for a flush request while one is pending
    always_comb begin
        frame_cnt_d = frame_cnt_q + {7'd0, frame_last};
        proto_err_d = proto_err_q ||
                      (ctl.flush_req && (flush_pend_q || (state_q == ST_FLUSH)));
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ctl.frame_cnt = frame_cnt_q;
    assign ctl.proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_r2mdc_stage_ctrl.sv
// tb_r2mdc_stage_ctrl: directed bench for the R2MDC stage controller.
// dut_a runs N=16, STAGE=1 (D=2, S=4, 3-bit address); dut_b runs N=8,
// STAGE=0 (D=2, S=4, 2-bit address). Optional macro R2MDC_CTRL_STATS_EN
// enables the statistics scenario.
module tb_r2mdc_stage_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    r2mdc_stage_ctrl_if #(.N(16)) ifa ();
    r2mdc_stage_ctrl_if #(.N(8))  ifb ();

    r2mdc_stage_ctrl #(.N(16), .STAGE(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ifa)
    );

    r2mdc_stage_ctrl #(.N(8), .STAGE(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ifb)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read 1 ns later
    task automatic drive_a(input logic v, input logic f);
        @(negedge clk);
        ifa.in_valid  = v;
        ifa.flush_req = f;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic f);
        @(negedge clk);
        ifb.in_valid  = v;
        ifb.flush_req = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.flush_req = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.flush_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got_a;
        logic [8:0] got_b;
        do_reset();
        got_a = {ifa.in_ready, ifa.flush_busy, ifa.sh_en, ifa.bf_en, ifa.frame_last,
                 ifa.sw_in, ifa.sw_out, ifa.tw_addr};
        n_cmp++;
        if (got_a !== 10'b1000000000) begin
            n_bad++;
            $display("[TB] FAIL reset_a: got %b expected %b", got_a, 10'b1000000000);
        end
        got_b = {ifb.in_ready, ifb.flush_busy, ifb.sh_en, ifb.bf_en, ifb.frame_last,
                 ifb.sw_in, ifb.sw_out, ifb.tw_addr};
        n_cmp++;
        if (got_b !== 9'b100000000) begin
            n_bad++;
            $display("[TB] FAIL reset_b: got %b expected %b", got_b, 9'b100000000);
        end
    endtask

    // Vector {bf_en, sh_en, frame_last, sw_in, sw_out, tw_addr[2:0]}
    task automatic test_continuous();
        logic [7:0] exp_v [10];
        logic [7:0] got;
        exp_v = '{8'b01000000, 8'b01000000, 8'b11010000, 8'b11011010, 8'b11001100,
                  8'b11000110, 8'b11010000, 8'b11011010, 8'b11001100, 8'b11100110};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive_a(1'b1, 1'b0);
            got = {ifa.bf_en, ifa.sh_en, ifa.frame_last, ifa.sw_in, ifa.sw_out, ifa.tw_addr};
            n_cmp++;
            if (got !== exp_v[k]) begin
                n_bad++;
                $display("[TB] FAIL cont_pair%0d: got %b expected %b", k + 1, got, exp_v[k]);
            end
        end
        drive_a(1'b0, 1'b0);
    endtask

    task automatic test_flush();
        logic [2:0] got3;
        logic [8:0] got9;
        logic [7:0] got8;
        logic [3:0] got4;
        logic [3:0] exp4 [3];
        do_reset();
        // Pairs 1..8, flush request alongside pair 5; {bf_en, in_ready, flush_busy}
        for (int k = 1; k <= 8; k++) begin
            drive_a(1'b1, (k == 5));
            got3 = {ifa.bf_en, ifa.in_ready, ifa.flush_busy};
            n_cmp++;
            if (got3 !== ((k <= 2) ? 3'b010 : 3'b110)) begin
                n_bad++;
                $display("[TB] FAIL flush_pair%0d: got %b expected %b", k, got3,
                         ((k <= 2) ? 3'b010 : 3'b110));
            end
        end
        // Drain cycles: butterflies 7 and 8 (bcnt 6,7 -> addr 4,6), input refused
        // Vector {in_ready, flush_busy, sh_en, bf_en, frame_last, sw_in, tw_addr}
        drive_a(1'b1, 1'b0);
        got9 = {ifa.in_ready, ifa.flush_busy, ifa.sh_en, ifa.bf_en, ifa.frame_last,
                ifa.sw_in, ifa.tw_addr};
        n_cmp++;
        if (got9 !== 9'b011100100) begin
            n_bad++;
            $display("[TB] FAIL flush_cyc1: got %b expected %b", got9, 9'b011100100);
        end
        drive_a(1'b1, 1'b0);
        got9 = {ifa.in_ready, ifa.flush_busy, ifa.sh_en, ifa.bf_en, ifa.frame_last,
                ifa.sw_in, ifa.tw_addr};
        n_cmp++;
        if (got9 !== 9'b011110110) begin
            n_bad++;
            $display("[TB] FAIL flush_cyc2: got %b expected %b", got9, 9'b011110110);
        end
        // Back in IDLE: {in_ready, flush_busy, sh_en, bf_en, frame_last, tw_addr}
        drive_a(1'b0, 1'b0);
        got8 = {ifa.in_ready, ifa.flush_busy, ifa.sh_en, ifa.bf_en, ifa.frame_last, ifa.tw_addr};
        n_cmp++;
        if (got8 !== 8'b10000000) begin
            n_bad++;
            $display("[TB] FAIL flush_idle: got %b expected %b", got8, 8'b10000000);
        end
        // Fresh frame refills for two pairs; {bf_en, tw_addr}
        exp4 = '{4'b0000, 4'b0000, 4'b1000};
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b0);
            got4 = {ifa.bf_en, ifa.tw_addr};
            n_cmp++;
            if (got4 !== exp4[k]) begin
                n_bad++;
                $display("[TB] FAIL flush_refill%0d: got %b expected %b", k + 1, got4, exp4[k]);
            end
        end
        drive_a(1'b0, 1'b0);
    endtask

    // Vector {bf_en, sh_en, sw_in, tw_addr}; starts at pcnt=5, bcnt=3
    task automatic test_bubbles();
        logic [5:0] exp_v [4];
        logic       pat   [4];
        logic [5:0] got;
        int         pulses;
        exp_v  = '{6'b110110, 6'b001000, 6'b001000, 6'b111000};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
        pulses = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            drive_a(pat[k], 1'b0);
            got = {ifa.bf_en, ifa.sh_en, ifa.sw_in, ifa.tw_addr};
            if (ifa.bf_en === 1'b1) begin
                pulses++;
            end
            n_cmp++;
            if (got !== exp_v[k]) begin
                n_bad++;
                $display("[TB] FAIL bubble_cyc%0d: got %b expected %b", k + 1, got, exp_v[k]);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_bad++;
            $display("[TB] FAIL bubble_pulses: got %0d expected 2", pulses);
        end
        drive_a(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        logic [1:0] got2;
        logic [1:0] exp2 [3];
        exp2 = '{2'b01, 2'b01, 2'b11};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, 1'b0);
        end
        @(negedge clk);
        rst_n        = 1'b0;
        ifa.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        got = {ifa.in_ready, ifa.flush_busy, ifa.sh_en, ifa.bf_en, ifa.frame_last,
               ifa.sw_in, ifa.sw_out, ifa.tw_addr};
        n_cmp++;
        if (got !== 10'b1000000000) begin
            n_bad++;
            $display("[TB] FAIL midreset_state: got %b expected %b", got, 10'b1000000000);
        end
        // {bf_en, sh_en}: restart fills for two accepts
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 1'b0);
            got2 = {ifa.bf_en, ifa.sh_en};
            n_cmp++;
            if (got2 !== exp2[k]) begin
                n_bad++;
                $display("[TB] FAIL midreset_pair%0d: got %b expected %b", k + 1, got2, exp2[k]);
            end
        end
        drive_a(1'b0, 1'b0);
    endtask

    // N=8 stage: {bf_en, flush_busy, in_ready, frame_last, tw_addr[1:0]}
    task automatic test_n8();
        logic [5:0] exp_v [6];
        logic [5:0] got;
        logic [1:0] got2;
        exp_v = '{6'b001000, 6'b001000, 6'b101000, 6'b101001, 6'b101010, 6'b101111};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_b(1'b1, (k == 1));
            got = {ifb.bf_en, ifb.flush_busy, ifb.in_ready, ifb.frame_last, ifb.tw_addr};
            n_cmp++;
            if (got !== exp_v[k]) begin
                n_bad++;
                $display("[TB] FAIL n8_pair%0d: got %b expected %b", k + 1, got, exp_v[k]);
            end
        end
        drive_b(1'b0, 1'b0);
        got2 = {ifb.flush_busy, ifb.in_ready};
        n_cmp++;
        if (got2 !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL n8_no_flush: got %b expected %b", got2, 2'b01);
        end
    endtask

`ifdef R2MDC_CTRL_STATS_EN
    task automatic test_stats();
        do_reset();
        // 18 pairs give butterflies 1..16 -> two frame_last pulses
        for (int k = 0; k < 18; k++) begin
            drive_a(1'b1, 1'b0);
        end
        drive_a(1'b0, 1'b0);
        n_cmp++;
        if (ifa.frame_cnt !== 8'd2) begin
            n_bad++;
            $display("[TB] FAIL stats_frames: got %0d expected 2", ifa.frame_cnt);
        end
        drive_a(1'b0, 1'b1);
        n_cmp++;
        if (ifa.proto_err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL stats_err_first: got %b expected 0", ifa.proto_err);
        end
        drive_a(1'b0, 1'b1);
        drive_a(1'b0, 1'b0);
        n_cmp++;
        if (ifa.proto_err !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL stats_err_set: got %b expected 1", ifa.proto_err);
        end
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b0, 1'b0);
        end
        n_cmp++;
        if (ifa.proto_err !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL stats_err_hold: got %b expected 1", ifa.proto_err);
        end
        do_reset();
        n_cmp++;
        if ({ifa.proto_err, ifa.frame_cnt} !== 9'd0) begin
            n_bad++;
            $display("[TB] FAIL stats_reset: got %b expected 0", {ifa.proto_err, ifa.frame_cnt});
        end
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.flush_req = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.flush_req = 1'b0;
        $display("[TB] start");
        test_reset();
        test_continuous();
        test_flush();
        test_bubbles();
        test_reset_mid();
        test_n8();
`ifdef R2MDC_CTRL_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
